// File: rtl/ttt_pkg.sv
// Shared types and board-access helpers for the tic-tac-toe game controller.
// Square n (1..9) occupies board bits [19-2n:18-2n].
package ttt_pkg;

  localparam int BOARD_W = 18;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    O     = 2'b01,
    X     = 2'b10
  } square_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    XWIN = 2'd1,
    OWIN = 2'd2
  } result_e;

  typedef enum logic [2:0] {
    ASK   = 3'd0,
    CHKU  = 3'd1,
    EVALU = 3'd2,
    AIREQ = 3'd3,
    CHKA  = 3'd4,
    EVALA = 3'd5,
    DONE  = 3'd6
  } state_e;

  function automatic logic [4:0] sq_lsb(input logic [3:0] n);
    case (n)
      4'd1:    sq_lsb = 5'd16;
      4'd2:    sq_lsb = 5'd14;
      4'd3:    sq_lsb = 5'd12;
      4'd4:    sq_lsb = 5'd10;
      4'd5:    sq_lsb = 5'd8;
      4'd6:    sq_lsb = 5'd6;
      4'd7:    sq_lsb = 5'd4;
      4'd8:    sq_lsb = 5'd2;
      4'd9:    sq_lsb = 5'd0;
      default: sq_lsb = 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] get_sq(input logic [BOARD_W-1:0] b, input logic [3:0] n);
    return 2'(b >> sq_lsb(n));
  endfunction

  function automatic logic [BOARD_W-1:0] set_sq(input logic [BOARD_W-1:0] b,
                                                input logic [3:0] n,
                                                input logic [1:0] v);
    logic [BOARD_W-1:0] mask;
    mask = BOARD_W'(2'b11) << sq_lsb(n);
    return (b & ~mask) | (BOARD_W'(v) << sq_lsb(n));
  endfunction

  // Codes outside 1..9 (e.g. a newline) are never legal.
  function automatic logic move_ok(input logic [BOARD_W-1:0] b, input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd9) && (get_sq(b, n) == EMPTY);
  endfunction

  function automatic logic [3:0] first_empty(input logic [BOARD_W-1:0] b);
    logic [3:0] f;
    f = 4'd0;
    for (int n = 9; n >= 1; n--) begin
      if (get_sq(b, 4'(n)) == EMPTY) f = 4'(n);
    end
    return f;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Move/result handshake bundle between the game controller and its user/AI agents.
interface game_ctrl_if;
  logic [3:0]  i_move;
  logic        i_validmove_stb;
  logic        i_busy;
  logic [3:0]  i_aimove;
  logic        i_aimove_stb;
  logic        i_newgame;
  logic [17:0] o_board;
  logic [1:0]  o_result;
  logic        o_isdraw;
  logic        o_result_stb;
  logic        o_needinput;
  logic        o_aireq;
  logic        o_badmove_stb;

  modport master (
    output i_move, i_validmove_stb, i_busy, i_aimove, i_aimove_stb, i_newgame,
    input  o_board, o_result, o_isdraw, o_result_stb, o_needinput, o_aireq, o_badmove_stb
  );

  modport slave (
    input  i_move, i_validmove_stb, i_busy, i_aimove, i_aimove_stb, i_newgame,
    output o_board, o_result, o_isdraw, o_result_stb, o_needinput, o_aireq, o_badmove_stb
  );
endinterface

// File: rtl/win_detect.sv
// Combinational board evaluation: three-in-a-row for X or O over the 8 lines,
// plus a full-board flag.
module win_detect
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  output logic               xwin_o,
  output logic               owin_o,
  output logic               full_o
);

  function automatic logic has_line(input logic [BOARD_W-1:0] b, input logic [1:0] c);
    logic [1:0] s [1:9];
    for (int n = 1; n <= 9; n++) s[n] = get_sq(b, 4'(n));
    return (s[1] == c && s[2] == c && s[3] == c) ||
           (s[4] == c && s[5] == c && s[6] == c) ||
           (s[7] == c && s[8] == c && s[9] == c) ||
           (s[1] == c && s[4] == c && s[7] == c) ||
           (s[2] == c && s[5] == c && s[8] == c) ||
           (s[3] == c && s[6] == c && s[9] == c) ||
           (s[1] == c && s[5] == c && s[9] == c) ||
           (s[3] == c && s[5] == c && s[7] == c);
  endfunction

  // Line and fullness evaluation of the current board
  always_comb begin
    xwin_o = has_line(board_i, X);
    owin_o = has_line(board_i, O);
    full_o = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      full_o = full_o & (get_sq(board_i, 4'(n)) != EMPTY);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller: user (O) moves first, FPGA (X) replies,
// board and result are held in registers and evaluated after each move.
module game_ctrl
  import ttt_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  game_ctrl_if.slave  bus
);

  state_e               state_q;
  logic [BOARD_W-1:0]   board_q;
  logic [3:0]           move_q;
  logic [3:0]           aimove_q;
  result_e              result_q;
  logic                 isdraw_q;
  logic                 result_stb_q;
  logic                 needinput_q;
  logic                 aireq_q;
  logic                 badmove_stb_q;

  logic                 xwin_s;
  logic                 owin_s;
  logic                 full_s;
  logic                 eval_end_d;
  logic                 eval_draw_d;
  result_e              eval_res_d;
  logic [3:0]           ai_sq_d;

  win_detect u_win (
    .board_i (board_q),
    .xwin_o  (xwin_s),
    .owin_o  (owin_s),
    .full_o  (full_s)
  );

  // Game outcome priority: O win, then X win, then draw; a line on the last square is a win
  always_comb begin
    if (owin_s) begin
      eval_end_d = 1'b1; eval_res_d = OWIN; eval_draw_d = 1'b0;
    end else if (xwin_s) begin
      eval_end_d = 1'b1; eval_res_d = XWIN; eval_draw_d = 1'b0;
    end else if (full_s) begin
      eval_end_d = 1'b1; eval_res_d = NONE; eval_draw_d = 1'b1;
    end else begin
      eval_end_d = 1'b0; eval_res_d = NONE; eval_draw_d = 1'b0;
    end
  end

  // FPGA square: its request if legal, otherwise the lowest empty square
  always_comb begin
    if (move_ok(board_q, aimove_q)) ai_sq_d = aimove_q;
    else                            ai_sq_d = first_empty(board_q);
  end

  // Game sequencer with registered board, result, strobes and requests
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ASK;
      board_q       <= '0;
      move_q        <= 4'd0;
      aimove_q      <= 4'd0;
      result_q      <= NONE;
      isdraw_q      <= 1'b0;
      result_stb_q  <= 1'b0;
      needinput_q   <= 1'b0;
      aireq_q       <= 1'b0;
      badmove_stb_q <= 1'b0;
    end else if (bus.i_newgame) begin
      state_q       <= ASK;
      board_q       <= '0;
      result_q      <= NONE;
      isdraw_q      <= 1'b0;
      result_stb_q  <= 1'b0;
      needinput_q   <= 1'b0;
      aireq_q       <= 1'b0;
      badmove_stb_q <= 1'b0;
    end else begin
      result_stb_q  <= 1'b0;
      needinput_q   <= 1'b0;
      aireq_q       <= 1'b0;
      badmove_stb_q <= 1'b0;
      case (state_q)
        ASK: begin
          if (bus.i_validmove_stb) begin
            move_q  <= bus.i_move;
            state_q <= CHKU;
          end else begin
            needinput_q <= !bus.i_busy;
          end
        end
        CHKU: begin
          if (move_ok(board_q, move_q)) begin
            board_q <= set_sq(board_q, move_q, O);
            state_q <= EVALU;
          end else begin
            badmove_stb_q <= 1'b1;
            needinput_q   <= !bus.i_busy;
            state_q       <= ASK;
          end
        end
        EVALU, EVALA: begin
          if (eval_end_d) begin
            result_q     <= eval_res_d;
            isdraw_q     <= eval_draw_d;
            result_stb_q <= 1'b1;
            state_q      <= DONE;
          end else if (state_q == EVALU) begin
            aireq_q <= 1'b1;
            state_q <= AIREQ;
          end else begin
            needinput_q <= !bus.i_busy;
            state_q     <= ASK;
          end
        end
        AIREQ: begin
          if (bus.i_aimove_stb) begin
            aimove_q <= bus.i_aimove;
            state_q  <= CHKA;
          end else begin
            aireq_q <= 1'b1;
          end
        end
        CHKA: begin
          // An empty square always exists here: a full board ends the game in EVALU
          if (ai_sq_d != 4'd0) board_q <= set_sq(board_q, ai_sq_d, X);
          state_q <= EVALA;
        end
        DONE: state_q <= DONE;
        default: state_q <= ASK;
      endcase
    end
  end

  assign bus.o_board       = board_q;
  assign bus.o_result      = result_q;
  assign bus.o_isdraw      = isdraw_q;
  assign bus.o_result_stb  = result_stb_q;
  assign bus.o_needinput   = needinput_q;
  assign bus.o_aireq       = aireq_q;
  assign bus.o_badmove_stb = badmove_stb_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a board/result model feeds scoreboard queues
// that are drained as the controller produces each board update and result.
module tb_game_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [17:0] mb = 18'h0;
  logic [17:0] exp_board_q [$];
  logic [2:0]  exp_res_q [$];

  always #5 clk = ~clk;

  game_ctrl_if bus ();
  game_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] msq(input logic [17:0] b, input int n);
    if (n < 1 || n > 9) return 2'b11;
    return b[19-2*n -: 2];
  endfunction

  function automatic logic [17:0] mset(input logic [17:0] b, input int n, input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[19-2*n -: 2] = v;
    return r;
  endfunction

  task automatic wait_needinput(input string tag);
    int n = 0;
    while (bus.o_needinput !== 1'b1 && n < 20) begin step(); n++; end
    chk({tag, "_needinput"}, 32'(bus.o_needinput), 32'd1);
  endtask

  task automatic wait_aireq(input string tag);
    int n = 0;
    while (bus.o_aireq !== 1'b1 && n < 20) begin step(); n++; end
    chk({tag, "_aireq"}, 32'(bus.o_aireq), 32'd1);
  endtask

  task automatic user_move(input int m, input string tag);
    logic ok;
    wait_needinput(tag);
    ok = (msq(mb, m) == 2'b00);
    if (ok) mb = mset(mb, m, 2'b01);
    exp_board_q.push_back(mb);
    bus.i_move = 4'(m);
    bus.i_validmove_stb = 1'b1;
    step();
    bus.i_validmove_stb = 1'b0;
    step();
    chk({tag, "_board"}, 32'(bus.o_board), 32'(exp_board_q.pop_front()));
    chk({tag, "_badmove"}, 32'(bus.o_badmove_stb), 32'(!ok));
  endtask

  task automatic ai_move(input int m, input string tag);
    int sq;
    wait_aireq(tag);
    sq = 0;
    if (msq(mb, m) == 2'b00) sq = m;
    else for (int n = 9; n >= 1; n--) if (msq(mb, n) == 2'b00) sq = n;
    mb = mset(mb, sq, 2'b10);
    exp_board_q.push_back(mb);
    bus.i_aimove = 4'(m);
    bus.i_aimove_stb = 1'b1;
    step();
    bus.i_aimove_stb = 1'b0;
    step();
    chk({tag, "_board"}, 32'(bus.o_board), 32'(exp_board_q.pop_front()));
  endtask

  task automatic expect_end(input string tag);
    int n = 0;
    logic [2:0] e;
    while (bus.o_result_stb !== 1'b1 && n < 10) begin step(); n++; end
    chk({tag, "_stb"}, 32'(bus.o_result_stb), 32'd1);
    e = exp_res_q.pop_front();
    chk({tag, "_result"}, 32'(bus.o_result), 32'(e[1:0]));
    chk({tag, "_isdraw"}, 32'(bus.o_isdraw), 32'(e[2]));
    chk({tag, "_req_at_stb"}, 32'({bus.o_aireq, bus.o_needinput}), 32'd0);
    step();
    chk({tag, "_stb_single"}, 32'(bus.o_result_stb), 32'd0);
    chk({tag, "_held"}, 32'({bus.o_isdraw, bus.o_result}), 32'(e));
    step();
    chk({tag, "_no_aireq"}, 32'(bus.o_aireq), 32'd0);
  endtask

  task automatic new_game(input string tag);
    bus.i_newgame = 1'b1;
    step();
    step();
    chk({tag, "_nb_board"}, 32'(bus.o_board), 32'd0);
    chk({tag, "_nb_res"}, 32'({bus.o_isdraw, bus.o_result}), 32'd0);
    chk({tag, "_nb_req"}, 32'({bus.o_needinput, bus.o_aireq, bus.o_result_stb}), 32'd0);
    bus.i_newgame = 1'b0;
    mb = 18'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_move = 4'd0; bus.i_validmove_stb = 1'b0; bus.i_busy = 1'b1;
    bus.i_aimove = 4'd0; bus.i_aimove_stb = 1'b0; bus.i_newgame = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_board", 32'(bus.o_board), 32'd0);
    chk("rst_result", 32'({bus.o_isdraw, bus.o_result}), 32'd0);
    chk("rst_strobes", 32'({bus.o_result_stb, bus.o_needinput, bus.o_aireq, bus.o_badmove_stb}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("busy_suppress", 32'(bus.o_needinput), 32'd0);
    bus.i_busy = 1'b0;
    step();
    chk("first_needinput", 32'(bus.o_needinput), 32'd1);

    // Basic exchange with literal board values
    user_move(5, "g1_u5");
    chk("g1_lit1", 32'(bus.o_board), 32'h00100);
    step();
    chk("g1_aireq_now", 32'(bus.o_aireq), 32'd1);
    ai_move(1, "g1_a1");
    chk("g1_lit2", 32'(bus.o_board), 32'h20100);
    wait_needinput("g1_ask");

    // Rejected user moves: occupied square, then a newline code
    user_move(5, "g2_occ");
    step();
    chk("g2_pulse_len", 32'(bus.o_badmove_stb), 32'd0);
    user_move(10, "g2_nl");
    chk("g2_nl_lit", 32'(bus.o_board), 32'h20100);
    wait_needinput("g2_back");

    // AI onto an occupied square falls back to square 1
    new_game("g3");
    user_move(5, "g3_u5");
    ai_move(5, "g3_a5");
    chk("g3_sq1", 32'(bus.o_board[17:16]), 32'd2);

    // O wins on row 1
    new_game("g4");
    user_move(1, "g4_u1"); ai_move(4, "g4_a4");
    user_move(2, "g4_u2"); ai_move(5, "g4_a5");
    exp_res_q.push_back({1'b0, 2'd2});
    user_move(3, "g4_u3");
    expect_end("g4");

    // X wins on row 2
    new_game("g5");
    user_move(1, "g5_u1"); ai_move(4, "g5_a4");
    user_move(2, "g5_u2"); ai_move(5, "g5_a5");
    user_move(9, "g5_u9");
    exp_res_q.push_back({1'b0, 2'd1});
    ai_move(6, "g5_a6");
    expect_end("g5");

    // Full board, no line: draw
    new_game("g6");
    user_move(1, "g6_u1"); ai_move(3, "g6_a3");
    user_move(2, "g6_u2"); ai_move(4, "g6_a4");
    user_move(6, "g6_u6"); ai_move(5, "g6_a5");
    user_move(7, "g6_u7"); ai_move(8, "g6_a8");
    exp_res_q.push_back({1'b1, 2'd0});
    user_move(9, "g6_u9");
    expect_end("g6");

    // Ninth square completes column 2: win, not draw
    new_game("g7");
    user_move(2, "g7_u2"); ai_move(1, "g7_a1");
    user_move(4, "g7_u4"); ai_move(3, "g7_a3");
    user_move(5, "g7_u5"); ai_move(6, "g7_a6");
    user_move(9, "g7_u9"); ai_move(7, "g7_a7");
    exp_res_q.push_back({1'b0, 2'd2});
    user_move(8, "g7_u8");
    expect_end("g7");

    // New game overrides a simultaneous AI strobe
    new_game("g8");
    user_move(5, "g8_u5");
    wait_aireq("g8");
    bus.i_newgame = 1'b1; bus.i_aimove = 4'd1; bus.i_aimove_stb = 1'b1;
    step();
    bus.i_aimove_stb = 1'b0;
    chk("g8_cleared", 32'(bus.o_board), 32'd0);
    chk("g8_aireq_drop", 32'(bus.o_aireq), 32'd0);
    bus.i_newgame = 1'b0;
    mb = 18'h0;
    step();
    chk("g8_ask", 32'(bus.o_needinput), 32'd1);
    chk("g8_board_still0", 32'(bus.o_board), 32'd0);

    // Asynchronous reset mid-game
    user_move(5, "g9_u5");
    wait_aireq("g9");
    #2;
    rst_n = 1'b0;
    #1;
    chk("g9_async_board", 32'(bus.o_board), 32'd0);
    chk("g9_async_out", 32'({bus.o_isdraw, bus.o_result, bus.o_result_stb, bus.o_needinput,
                              bus.o_aireq, bus.o_badmove_stb}), 32'd0);
    step();
    step();
    chk("g9_no_stb", 32'(bus.o_result_stb), 32'd0);
    rst_n = 1'b1;
    mb = 18'h0;
    step();
    chk("g9_restart", 32'(bus.o_needinput), 32'd1);

    chk("sb_board_empty", 32'(exp_board_q.size()), 32'd0);
    chk("sb_res_empty", 32'(exp_res_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
